// File: rtl/pcie_csr_regs.sv
// AXI4-Lite CSR slave for the PCIe subsystem feature window: DFH, scratchpad,
// link status and sticky per-link error bits. One read and one write in flight.
module pcie_csr_regs #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int                NUM_LINKS = 1,
    parameter logic [63:0]       DFH_VALUE = 64'h3000_0000_1000_0020
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [63:0]          s_wdata,
    input  logic [7:0]           s_wstrb,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ADDR_W-1:0]    s_araddr,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [63:0]          s_rdata,
    output logic [1:0]           s_rresp,
    input  logic [NUM_LINKS-1:0] link_up,
    input  logic [NUM_LINKS-1:0] err_pulse
);

    localparam logic [ADDR_W-1:0] WIN_MASK    = {{(ADDR_W-12){1'b1}}, 12'h000};
    localparam logic [ADDR_W-1:0] OFF_MASK    = {{(ADDR_W-12){1'b0}}, 12'hFF8};
    localparam logic [11:0]       OFF_DFH     = 12'h000;
    localparam logic [11:0]       OFF_SCRATCH = 12'h008;
    localparam logic [11:0]       OFF_STAT    = 12'h010;
    localparam logic [11:0]       OFF_ERROR   = 12'h018;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // Expand byte enables into a 64-bit bit mask.
    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = 64'h0;
        for (int k = 0; k < 8; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wstrb;
    logic [63:0]           r_scratch;
    logic [63:0]           r_error;
    logic [NUM_LINKS-1:0]  r_link_up;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_have;
    logic                  w_w_have;
    logic                  w_do_write;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [63:0]           w_wr_data;
    logic [7:0]            w_wr_strb;
    logic [11:0]           w_wr_off;
    logic                  w_wr_in_win;
    logic [63:0]           w_wmask;
    logic [63:0]           w_scratch_next;
    logic [63:0]           w_err_clr;
    logic [1:0]            w_wr_resp;
    logic [63:0]           w_pulse_ext;
    logic [11:0]           w_ar_off;
    logic                  w_ar_in_win;
    logic [63:0]           w_rd_data;
    logic [1:0]            w_rd_resp;

    assign w_aw_hs     = s_awvalid & s_awready;
    assign w_w_hs      = s_wvalid & s_wready;
    assign w_aw_have   = r_aw_held | w_aw_hs;
    assign w_w_have    = r_w_held | w_w_hs;
    assign w_do_write  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;
    // A beat arriving this cycle is used directly so the update needs no extra cycle.
    assign w_wr_addr   = w_aw_hs ? s_awaddr : r_awaddr;
    assign w_wr_data   = w_w_hs ? s_wdata : r_wdata;
    assign w_wr_strb   = w_w_hs ? s_wstrb : r_wstrb;
    assign w_wr_off    = 12'(w_wr_addr & OFF_MASK);
    assign w_wr_in_win = (((w_wr_addr ^ BASE_ADDR) & WIN_MASK) == '0);
    assign w_ar_off    = 12'(s_araddr & OFF_MASK);
    assign w_ar_in_win = (((s_araddr ^ BASE_ADDR) & WIN_MASK) == '0);
    assign w_pulse_ext = {{(64-NUM_LINKS){1'b0}}, err_pulse};
    assign w_wmask     = strb_mask(w_wr_strb);

    // Write decode: next scratch value, error clear mask and response code.
    always_comb begin
        w_scratch_next = r_scratch;
        w_err_clr      = 64'h0;
        w_wr_resp      = RESP_OKAY;
        if (!w_do_write) begin
            w_wr_resp = RESP_OKAY;
        end else if (!w_wr_in_win) begin
            w_wr_resp = RESP_SLVERR;
        end else begin
            case (w_wr_off)
                OFF_SCRATCH: w_scratch_next = (r_scratch & ~w_wmask) | (w_wr_data & w_wmask);
                OFF_ERROR:   w_err_clr      = w_wr_data & w_wmask;
                default:     w_wr_resp      = RESP_OKAY;
            endcase
        end
    end

    // Read decode of the current (pre-write) register contents.
    always_comb begin
        w_rd_data = 64'h0;
        w_rd_resp = RESP_OKAY;
        if (!w_ar_in_win) begin
            w_rd_resp = RESP_SLVERR;
        end else begin
            case (w_ar_off)
                OFF_DFH:     w_rd_data = DFH_VALUE;
                OFF_SCRATCH: w_rd_data = r_scratch;
                OFF_STAT:    w_rd_data = {{(64-NUM_LINKS){1'b0}}, r_link_up};
                OFF_ERROR:   w_rd_data = r_error;
                default:     w_rd_data = 64'h0;
            endcase
        end
    end

    // Register storage; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= 64'h0;
            r_error   <= 64'h0;
            r_link_up <= '0;
        end else begin
            r_scratch <= w_scratch_next;
            r_error   <= (r_error & ~w_err_clr) | w_pulse_ext;
            r_link_up <= link_up;
        end
    end

    // Write channel FSM: independent AW/W capture, then hold B until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= 64'h0;
            r_wstrb   <= 8'h00;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_do_write) begin
                        r_wstate  <= W_RESP;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= w_wr_resp;
                    end else begin
                        r_aw_held <= w_aw_have;
                        r_w_held  <= w_w_have;
                        r_awaddr  <= w_wr_addr;
                        r_wdata   <= w_wr_data;
                        r_wstrb   <= w_wr_strb;
                        s_awready <= ~w_aw_have;
                        s_wready  <= ~w_w_have;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_wstate  <= W_IDLE;
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end else begin
                        s_bvalid  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    s_awready <= 1'b0;
                    s_wready  <= 1'b0;
                    s_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: capture data on AR handshake, hold R until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= 64'h0;
            s_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_arvalid && s_arready) begin
                        r_rstate  <= R_DATA;
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rdata   <= w_rd_data;
                        s_rresp   <= w_rd_resp;
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_rstate  <= R_IDLE;
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                    end else begin
                        s_rvalid  <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    s_arready <= 1'b0;
                    s_rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_csr_regs.sv
// Directed bench for pcie_csr_regs: register map, RW1C errors, strobes,
// decode errors, write-channel ordering/backpressure and mid-transaction reset.
module tb_pcie_csr_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_awvalid = 1'b0, s_awready;
    logic [31:0] s_awaddr = 32'h0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [63:0] s_wdata = 64'h0;
    logic [7:0]  s_wstrb = 8'h00;
    logic        s_bvalid, s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0, s_arready;
    logic [31:0] s_araddr = 32'h0;
    logic        s_rvalid, s_rready = 1'b0;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [0:0]  link_up = 1'b0;
    logic [0:0]  err_pulse = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [63:0] DFH = 64'h3000_0000_1000_0020;

    always #5 clk = ~clk;

    pcie_csr_regs dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .link_up(link_up), .err_pulse(err_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full write; optional err_pulse asserted in the cycle the beats are offered.
    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             input logic pulse, output logic [1:0] resp);
        bit aw_pend = 1'b1, w_pend = 1'b1, ag, wg, first = 1'b1;
        int t = 0;
        @(negedge clk);
        s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
        err_pulse = pulse;
        while ((aw_pend || w_pend) && t < 50) begin
            ag = s_awready; wg = s_wready;
            @(posedge clk); #1;
            if (first) begin err_pulse = 1'b0; first = 1'b0; end
            if (aw_pend && ag) begin aw_pend = 1'b0; s_awvalid = 1'b0; end
            if (w_pend && wg) begin w_pend = 1'b0; s_wvalid = 1'b0; end
            @(negedge clk); t++;
        end
        while (!s_bvalid && t < 50) begin @(negedge clk); t++; end
        check("wr_timeout", 64'(t >= 50), 64'h0);
        resp = s_bresp;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
        bit pend = 1'b1, g;
        int t = 0;
        @(negedge clk);
        s_arvalid = 1'b1; s_araddr = a;
        while (pend && t < 50) begin
            g = s_arready;
            @(posedge clk); #1;
            if (g) begin pend = 1'b0; s_arvalid = 1'b0; end
            @(negedge clk); t++;
        end
        while (!s_rvalid && t < 50) begin @(negedge clk); t++; end
        check("rd_timeout", 64'(t >= 50), 64'h0);
        d = s_rdata; resp = s_rresp;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0; s_arvalid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a,
                            input logic [63:0] exp_d, input logic [1:0] exp_r);
        logic [63:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_resp"}, 64'(r), 64'(exp_r));
    endtask

    task automatic write_chk(input string tag, input logic [31:0] a, input logic [63:0] d,
                             input logic [7:0] s, input logic pulse, input logic [1:0] exp_r);
        logic [1:0] r;
        axi_write(a, d, s, pulse, r);
        check({tag, "_bresp"}, 64'(r), 64'(exp_r));
    endtask

    initial begin
        logic [63:0] rd_same;
        logic [1:0]  rr_same, br_same;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_awready), 64'h0);
        check("rst_arready", 64'(s_arready), 64'h0);
        check("rst_bvalid",  64'(s_bvalid),  64'h0);
        check("rst_rvalid",  64'(s_rvalid),  64'h0);
        check("rst_rdata",   s_rdata,        64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 64'(s_awready), 64'h1);
        check("post_rst_wready",  64'(s_wready),  64'h1);
        check("post_rst_arready", 64'(s_arready), 64'h1);

        // Map basics and scratch strobes
        read_chk("dfh", 32'h0001_0000, DFH, 2'b00);
        read_chk("scratch_rst", 32'h0001_0008, 64'h0, 2'b00);
        write_chk("scr_wr_ff", 32'h0001_0008, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 2'b00);
        read_chk("scr_rd_ff", 32'h0001_0008, 64'hDEAD_BEEF_0123_4567, 2'b00);
        write_chk("scr_wr_0f", 32'h0001_0008, 64'h0, 8'h0F, 1'b0, 2'b00);
        read_chk("scr_rd_0f", 32'h0001_0008, 64'hDEAD_BEEF_0000_0000, 2'b00);
        write_chk("scr_wr_00", 32'h0001_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 2'b00);
        read_chk("scr_unaligned", 32'h0001_000F, 64'hDEAD_BEEF_0000_0000, 2'b00);
        write_chk("dfh_wr", 32'h0001_0000, 64'h0, 8'hFF, 1'b0, 2'b00);
        read_chk("dfh_after_wr", 32'h0001_0000, DFH, 2'b00);

        // Link status
        read_chk("stat_down", 32'h0001_0010, 64'h0, 2'b00);
        link_up = 1'b1;
        repeat (2) @(posedge clk);
        read_chk("stat_up", 32'h0001_0010, 64'h1, 2'b00);

        // Sticky error, RW1C with strobe coverage, set beats clear
        read_chk("err_rst", 32'h0001_0018, 64'h0, 2'b00);
        @(negedge clk); err_pulse = 1'b1;
        @(negedge clk); err_pulse = 1'b0;
        repeat (3) @(posedge clk);
        read_chk("err_set", 32'h0001_0018, 64'h1, 2'b00);
        write_chk("err_wr_nostrb", 32'h0001_0018, 64'h1, 8'h02, 1'b0, 2'b00);
        read_chk("err_kept", 32'h0001_0018, 64'h1, 2'b00);
        write_chk("err_wr_clr", 32'h0001_0018, 64'h1, 8'h01, 1'b0, 2'b00);
        read_chk("err_clr", 32'h0001_0018, 64'h0, 2'b00);
        write_chk("err_wr_race", 32'h0001_0018, 64'h1, 8'hFF, 1'b1, 2'b00);
        read_chk("err_set_wins", 32'h0001_0018, 64'h1, 2'b00);

        // Unmapped and out-of-window
        read_chk("unmapped", 32'h0001_0FF8, 64'h0, 2'b00);
        write_chk("unmapped_wr", 32'h0001_0FF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 2'b00);
        read_chk("unmapped_after", 32'h0001_0FF8, 64'h0, 2'b00);
        read_chk("oow", 32'h0002_0000, 64'h0, 2'b10);
        read_chk("oow_dfh_alias", 32'h0002_0000, 64'h0, 2'b10);
        write_chk("oow_wr", 32'h0002_0008, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 2'b10);
        read_chk("scr_after_oow", 32'h0001_0008, 64'hDEAD_BEEF_0000_0000, 2'b00);

        // W three cycles ahead of AW, then B backpressure
        @(negedge clk);
        s_wvalid = 1'b1; s_wdata = 64'h1111_2222_3333_4444; s_wstrb = 8'hFF;
        @(posedge clk); #1; s_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wfirst_wready",  64'(s_wready),  64'h0);
        check("wfirst_awready", 64'(s_awready), 64'h1);
        check("wfirst_bvalid",  64'(s_bvalid),  64'h0);
        s_awvalid = 1'b1; s_awaddr = 32'h0001_0008;
        @(posedge clk); #1; s_awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid",  64'(s_bvalid),  64'h1);
            check("bp_awready", 64'(s_awready), 64'h0);
            check("bp_wready",  64'(s_wready),  64'h0);
            check("bp_bresp",   64'(s_bresp),   64'h0);
        end
        s_bready = 1'b1;
        @(posedge clk); #1; s_bready = 1'b0;
        @(negedge clk);
        check("bp_done_bvalid",  64'(s_bvalid),  64'h0);
        check("bp_done_awready", 64'(s_awready), 64'h1);
        read_chk("wfirst_data", 32'h0001_0008, 64'h1111_2222_3333_4444, 2'b00);

        // Concurrent read and write of scratch: read sees the old value
        fork
            axi_write(32'h0001_0008, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, br_same);
            axi_read(32'h0001_0008, rd_same, rr_same);
        join
        check("same_cyc_rd", rd_same, 64'h1111_2222_3333_4444);
        check("same_cyc_bresp", 64'(br_same), 64'h0);
        read_chk("same_cyc_after", 32'h0001_0008, 64'h5555_6666_7777_8888, 2'b00);

        // Reset with a read response pending
        @(negedge clk);
        s_arvalid = 1'b1; s_araddr = 32'h0001_0008;
        @(posedge clk); #1; s_arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 64'(s_rvalid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid",  64'(s_rvalid),  64'h0);
        check("mid_rst_arready", 64'(s_arready), 64'h0);
        @(negedge clk); rst_n = 1'b1;
        read_chk("rst_scratch", 32'h0001_0008, 64'h0, 2'b00);
        read_chk("rst_error", 32'h0001_0018, 64'h0, 2'b00);
        read_chk("rst_stat", 32'h0001_0010, 64'h1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pcie_csr_regs.md
Name: pcie_csr_regs

Overview:
AXI4-Lite CSR slave implementing the PCIe subsystem feature register window: DFH at 0x10000, scratchpad at +0x8, status at +0x10, sticky error at +0x18, rest of the 4 KB window reserved. Sits between the FME/host CSR interconnect (upstream master) and the PCIe subsystem status/error signals. One outstanding read and one outstanding write.

Parameters:
ADDR_W, 32, AXI-Lite address width.
BASE_ADDR, 32'h10000, window base; 4 KB aligned.
NUM_LINKS, 1, PCIe links reported (1..32).
DFH_VALUE, 64'h3000_0000_1000_0020, read-only DFH contents.

Ports:
clk  in  1  CSR clock
rst_n  in  1  async active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_W  write byte address
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  64  write data
s_wstrb  in  8  byte enables
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  read byte address
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  64  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
link_up  in  NUM_LINKS  per-link up level
err_pulse  in  NUM_LINKS  one-cycle error event per link

Behaviour:
- Reset (async assert, sync deassert): all ready/valid outputs 0, bresp/rresp/rdata 0, scratchpad 0, error 0. Readies go 1 the first cycle after rst_n high.
- Decode: in-window when addr[ADDR_W-1:12]==BASE_ADDR[ADDR_W-1:12]; offset=addr[11:3]<<3, addr[2:0] ignored.
- Map: 0x000 DFH RO =DFH_VALUE; 0x008 SCRATCH RW, byte-strobed; 0x010 STAT RO, [NUM_LINKS-1:0]=link_up registered 1 cycle, upper bits 0; 0x018 ERROR RW1C sticky, [NUM_LINKS-1:0].
- In-window unmapped (e.g. 0xFF8): read 0 OKAY, write ignored OKAY. Out-of-window: read 0 SLVERR, write ignored SLVERR. Writes to DFH/STAT ignored, OKAY.
- Write FSM W_IDLE -> W_RESP: awready/wready each high while its beat is not yet captured and bvalid=0; AW and W captured independently in any order or same cycle. When both held, register update occurs that cycle, bvalid=1 next cycle (W_RESP). bvalid holds with stable bresp until bready; then W_IDLE, readies high next cycle. Minimum 2 cycles AW/W accept to next accept.
- Read FSM R_IDLE -> R_DATA: arready=!rvalid. On ar handshake, rdata/rresp registered, rvalid=1 next cycle; held stable until rready, then arready=1 next cycle.
- ERROR: bit set when err_pulse[i]=1; cleared when write with wdata[i]=1 and wstrb byte covering bit i. Same-cycle set and clear: set wins.
- Scratch: byte k updated only if wstrb[k]; wstrb=0 is a legal no-op with OKAY.
- Read and write may complete same cycle to same register; read returns pre-write value.
- Reset mid-transaction: outstanding handshakes dropped, no response issued, registers cleared.

Test Plan:
- Post-reset read 0x10000 -> rdata=64'h3000_0000_1000_0020, OKAY; read 0x10008 -> 0.
- Write 0x10008 data 64'hDEAD_BEEF_0123_4567 wstrb 8'hFF, readback -> same; then wstrb 8'h0F data 0 -> readback 64'hDEAD_BEEF_0000_0000.
- link_up=1, read 0x10010 -> 64'h1; err_pulse 1 cycle, read 0x10018 -> 1; write 1 -> readback 0; write with err_pulse same cycle -> readback 1.
- Read 0x10FF8 -> 0 OKAY; write then read 0x10FF8 -> 0; read 0x20000 -> 0 SLVERR; write 0x20000 -> bresp SLVERR, scratch unchanged.
- W beat 3 cycles before AW, bready held low 5 cycles -> bvalid stays 1, awready/wready 0, single register update.
- Assert rst_n low while rvalid=1 -> rvalid=0 immediately, scratch 0, next read after reset OKAY.
